// File: rtl/divider_10bits_pkg.sv
// Shared constants and state encoding for the 10-bit sequential restoring divider.
package divider_10bits_pkg;

   localparam int WIDTH = 10;
   localparam int CNT_W = 4;
   localparam int SUB_W = WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/divider_10bits_sub_11bits.sv
// 11-bit two's-complement subtractor: ripple add of a, ~b and a forced carry-in.
// cout_o = 1 means no borrow, i.e. a_i >= b_i as unsigned values.
module sub_11bits
   import divider_10bits_pkg::*;
(
   input  logic [SUB_W-1:0] a_i,
   input  logic [SUB_W-1:0] b_i,
   output logic [SUB_W-1:0] diff_o,
   output logic             cout_o
);

   logic [SUB_W-1:0] b_n;
   logic             carry;

   assign b_n = ~b_i;

   always_comb begin
      diff_o = '0;
      carry  = 1'b1;
      for (int i = 0; i < SUB_W; i++) begin
         diff_o[i] = a_i[i] ^ b_n[i] ^ carry;
         carry     = (a_i[i] & b_n[i]) | (carry & (a_i[i] ^ b_n[i]));
      end
      cout_o = carry;
   end

endmodule

// File: rtl/divider_10bits.sv
// Sequential restoring divider: one quotient bit per clock through a start/busy/done
// handshake, unsigned operands, divide-by-zero flagged in one cycle.
module divider_10bits
   import divider_10bits_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   remo_q, remo_d;
   logic               div0_q, div0_d;

   logic [WIDTH-1:0]   rem_shift;
   logic [WIDTH-1:0]   rem_iter;
   logic [WIDTH-1:0]   acc_iter;
   logic [SUB_W-1:0]   trial;
   logic               no_borrow;
   logic               unused_bits;

   // The partial remainder never exceeds the dividend prefix, so its shifted value fits WIDTH bits.
   assign rem_shift = {rem_q[WIDTH-2:0], acc_q[WIDTH-1]};

   sub_11bits u_sub (
      .a_i    ({1'b0, rem_shift}),
      .b_i    ({1'b0, dvs_q}),
      .diff_o (trial),
      .cout_o (no_borrow)
   );

   assign unused_bits = rem_q[WIDTH-1] ^ trial[WIDTH];

   assign rem_iter = no_borrow ? trial[WIDTH-1:0] : rem_shift;
   assign acc_iter = {acc_q[WIDTH-2:0], no_borrow};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      div0_d  = div0_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               dvs_d  = divisor;
               acc_d  = dividend;
               rem_d  = '0;
               quot_d = '0;
               remo_d = '0;
               div0_d = 1'b0;
               if (divisor == '0) begin
                  state_d = DONE;
                  quot_d  = DIV0_QUOTIENT;
                  remo_d  = dividend;
                  div0_d  = 1'b1;
               end else begin
                  state_d = RUN;
                  cnt_d   = CNT_W'(WIDTH - 1);
               end
            end
         end
         RUN: begin
            rem_d = rem_iter;
            acc_d = acc_iter;
            if (cnt_q == '0) begin
               state_d = DONE;
               quot_d  = acc_iter;
               remo_d  = rem_iter;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         acc_q   <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         remo_q  <= '0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         div0_q  <= div0_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = remo_q;
   assign div_by_zero = div0_q;

endmodule

// File: tb/tb_divider_10bits.sv
// Self-checking bench for divider_10bits: directed table, ignored-start, mid-operation
// reset and randomised pairs against a plain-arithmetic reference.
module tb_divider_10bits;
   import divider_10bits_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] dividend = '0;
   logic [WIDTH-1:0] divisor = '0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int nchk = 0;
   int nerr = 0;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      bit               z;
      bit               ign;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   divider_10bits dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Starts at a negedge in IDLE; returns at the negedge of the IDLE cycle after done.
   task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                          input bit ez, input bit ign, input string tag);
      int k;
      int busy_n;
      bit seen;
      int exp_cyc;
      exp_cyc  = (b == 0) ? 1 : WIDTH + 1;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      k = 0;
      busy_n = 0;
      seen = 1'b0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         start = 1'b0;
         if (ign && (k == 3 || k == 10)) begin
            start    = 1'b1;
            dividend = 10'd50;
            divisor  = 10'd5;
         end
         if (busy) busy_n++;
         if (done) seen = 1'b1;
      end
      if (!seen) chk({tag, " timeout"}, 0, 1);
      chk({tag, " done_cycle"}, k, exp_cyc);
      chk({tag, " busy_cycles"}, busy_n, k);
      chk({tag, " quotient"}, int'(quotient), int'(eq));
      chk({tag, " remainder"}, int'(remainder), int'(er));
      chk({tag, " div_by_zero"}, int'(div_by_zero), int'(ez));
      $display("div %0d/%0d -> q=%0d r=%0d z=%0d done@cycle %0d", a, b, quotient, remainder,
               div_by_zero, k);
      @(negedge clk);
      start = 1'b0;
      chk({tag, " done_low_after"}, int'(done), 0);
      chk({tag, " busy_low_after"}, int'(busy), 0);
      chk({tag, " q_held"}, int'(quotient), int'(eq));
      chk({tag, " r_held"}, int'(remainder), int'(er));
   endtask

   initial begin
      int qm;
      int rm;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;

      vecs[0] = '{10'd100,  10'd7,    10'd14,   10'd2,   1'b0, 1'b0};
      vecs[1] = '{10'd1023, 10'd1,    10'd1023, 10'd0,   1'b0, 1'b0};
      vecs[2] = '{10'd1023, 10'd1023, 10'd1,    10'd0,   1'b0, 1'b0};
      vecs[3] = '{10'd5,    10'd10,   10'd0,    10'd5,   1'b0, 1'b0};
      vecs[4] = '{10'd37,   10'd0,    10'h3FF,  10'd37,  1'b1, 1'b0};
      vecs[5] = '{10'd9,    10'd3,    10'd3,    10'd0,   1'b0, 1'b0};
      vecs[6] = '{10'd200,  10'd9,    10'd22,   10'd2,   1'b0, 1'b1};
      vecs[7] = '{10'd0,    10'd5,    10'd0,    10'd0,   1'b0, 1'b0};
      vecs[8] = '{10'd1,    10'd1023, 10'd0,    10'd1,   1'b0, 1'b0};
      vecs[9] = '{10'd1023, 10'd2,    10'd511,  10'd1,   1'b0, 1'b0};

      repeat (2) @(negedge clk);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset quotient", int'(quotient), 0);
      chk("reset remainder", int'(remainder), 0);
      chk("reset div_by_zero", int'(div_by_zero), 0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].ign,
                 $sformatf("vec%0d", i));
      end

      // Reset while a division is in flight.
      dividend = 10'd500;
      divisor  = 10'd3;
      start    = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("midrst busy_before", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst busy", int'(busy), 0);
      chk("midrst done", int'(done), 0);
      chk("midrst quotient", int'(quotient), 0);
      chk("midrst remainder", int'(remainder), 0);
      chk("midrst div_by_zero", int'(div_by_zero), 0);
      begin
         int dones;
         dones = 0;
         repeat (12) begin
            @(negedge clk);
            if (done) dones++;
         end
         chk("midrst no_done", dones, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      run_div(10'd500, 10'd3, 10'd166, 10'd2, 1'b0, 1'b0, "after_reset");

      for (int n = 0; n < 30; n++) begin
         ra = WIDTH'($urandom_range(0, 1023));
         rb = WIDTH'($urandom_range(1, 1023));
         qm = int'(ra) / int'(rb);
         rm = int'(ra) % int'(rb);
         run_div(ra, rb, WIDTH'(qm), WIDTH'(rm), 1'b0, 1'b0, $sformatf("rnd%0d", n));
         chk($sformatf("rnd%0d identity", n), int'(quotient) * int'(rb) + int'(remainder),
             int'(ra));
         chk($sformatf("rnd%0d rem_lt_div", n), int'(remainder < rb), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
